// File: rtl/seq_pattern_gen_if.sv
// Request/stream bundle between a pattern requester (master) and seq_pattern_gen (slave).
interface seq_pattern_gen_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pat;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] rep;
    logic [CNT_W-1:0] gap;
    logic             dout;
    logic             dout_vld;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output start, abort, pat, len, rep, gap,
        input  dout, dout_vld, busy, done, frame_cnt
    );

    modport slave (
        input  start, abort, pat, len, rep, gap,
        output dout, dout_vld, busy, done, frame_cnt
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial test-pattern generator: shifts a captured pattern out MSB-first,
// repeating it rep+1 times with an optional idle gap between frames.
module seq_pattern_gen #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    seq_pattern_gen_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, FIN} state_t;

    localparam logic [CNT_W-1:0] PAT_W_C = CNT_W'(PAT_W);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state;
    logic [PAT_W-1:0] pat_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] rep_q;
    logic [CNT_W-1:0] gap_q;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] frame_cnt_r;
    logic             dout_r;
    logic             dout_vld_r;
    logic             busy_r;
    logic             done_r;

    logic [CNT_W-1:0] len_in_eff;
    logic             first_in_bit;
    logic             reload_bit;
    logic             next_bit;

    // Shift-based bit select keeps the index width independent of PAT_W.
    function automatic logic pick(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] i);
        logic [PAT_W-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    always_comb begin
        len_in_eff   = (bus.len == '0 || bus.len > PAT_W_C) ? PAT_W_C : bus.len;
        first_in_bit = pick(bus.pat, len_in_eff - ONE);
        reload_bit   = pick(pat_q, len_q - ONE);
        next_bit     = pick(pat_q, idx - ONE);
    end

    // Outputs are computed for the cycle that follows each edge, so idx always
    // names the bit currently on dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            rep_q       <= '0;
            gap_q       <= '0;
            idx         <= '0;
            gap_cnt     <= '0;
            frame_cnt_r <= '0;
            dout_r      <= 1'b0;
            dout_vld_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        pat_q       <= bus.pat;
                        len_q       <= len_in_eff;
                        rep_q       <= bus.rep;
                        gap_q       <= bus.gap;
                        frame_cnt_r <= '0;
                        idx         <= len_in_eff - ONE;
                        dout_r      <= first_in_bit;
                        dout_vld_r  <= 1'b1;
                        busy_r      <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.abort || (idx == '0 && frame_cnt_r == rep_q)) begin
                        dout_r     <= 1'b0;
                        dout_vld_r <= 1'b0;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        state      <= FIN;
                    end else if (idx == '0) begin
                        frame_cnt_r <= frame_cnt_r + ONE;
                        idx         <= len_q - ONE;
                        if (gap_q != '0) begin
                            gap_cnt    <= gap_q;
                            dout_r     <= 1'b0;
                            dout_vld_r <= 1'b0;
                            state      <= GAP;
                        end else begin
                            dout_r     <= reload_bit;
                            dout_vld_r <= 1'b1;
                        end
                    end else begin
                        idx    <= idx - ONE;
                        dout_r <= next_bit;
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= FIN;
                    end else if (gap_cnt == ONE) begin
                        dout_r     <= reload_bit;
                        dout_vld_r <= 1'b1;
                        state      <= SHIFT;
                    end else begin
                        gap_cnt <= gap_cnt - ONE;
                    end
                end
                FIN: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    dout_r     <= 1'b0;
                    dout_vld_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.dout      = dout_r;
    assign bus.dout_vld  = dout_vld_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.frame_cnt = frame_cnt_r;

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Serial test-pattern generator that drives a single-bit stream into the sequence-check FSMs of the FSM lab. On a `start` pulse it captures a pattern word, a bit length, a repeat count and an inter-frame gap. It then shifts the pattern out MSB-first, one bit per clock, with a qualifying valid strobe. It is the transmit-side counterpart of the sequence detectors and provides their stimulus on-board as well as in simulation.

## Interface
- `PAT_W`, 8: pattern register width in bits (2..15).
- `CNT_W`, 4: width of `len`, `rep`, `gap` and `frame_cnt`; must satisfy 2^CNT_W > PAT_W.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `abort`  in  1  synchronous stop request.
- `pat`  in  PAT_W  pattern; bit `len-1` is sent first.
- `len`  in  CNT_W  bits per frame.
- `rep`  in  CNT_W  extra frames; total frames = `rep+1`.
- `gap`  in  CNT_W  idle cycles between consecutive frames.
- `dout`  out  1  serial data; 0 whenever `dout_vld`=0.
- `dout_vld`  out  1  `dout` carries a pattern bit this cycle.
- `busy`  out  1  high in SHIFT and GAP.
- `done`  out  1  one-cycle completion pulse.
- `frame_cnt`  out  CNT_W  0-based index of the frame in progress.

## Operation
- FSM states: IDLE, SHIFT, GAP, FIN. All outputs are registered.
- **IDLE**
  - `start`=1 and `abort`=0: capture `pat`, `len`, `rep`, `gap` into shadow registers, clear `frame_cnt` and go to SHIFT.
  - `abort`=1: `start` is ignored and the FSM stays in IDLE.
- **Length rules**
  - `len`=0 or `len`>PAT_W is treated as PAT_W.
  - Bit index counter loads `len_eff-1` and counts down to 0.
- **SHIFT**
  - Each cycle: `dout`=pattern[idx], `dout_vld`=1.
  - After the index-0 bit, if `frame_cnt`==rep, go to FIN.
  - Otherwise increment `frame_cnt` and reload idx. Go to GAP if captured `gap`>0; else stay in SHIFT, so frames run back-to-back.
- **GAP**
  - Lasts exactly `gap` cycles with `dout`=0 and `dout_vld`=0, then returns to SHIFT.
- **FIN**
  - One cycle: `done`=1, `busy`=0, `dout_vld`=0.
  - `start` in FIN is ignored. Next state is IDLE.
- **abort** in SHIFT or GAP
  - Next cycle is FIN (`done` pulses) and `dout_vld`=0.
  - The bit being presented in the abort cycle still counts as sent.
- Changes on `pat`, `len`, `rep` and `gap` while `busy` have no effect.
- **Reset** (asynchronous, at any point including mid-frame)
  - State goes to IDLE immediately.
  - `dout`=0, `dout_vld`=0, `busy`=0, `done`=0, `frame_cnt`=0; shadow registers are cleared.
  - No `done` is produced for the aborted transfer.

## Timing
- `start` sampled high at edge E0 puts the first bit on `dout`/`dout_vld` in the cycle after E0, one cycle of latency.
- Frame k (0-based) first bit appears at cycle 1 + k·(len_eff+gap) relative to the accepting edge.
- `done` is high at cycle (rep+1)·len_eff + rep·gap + 1 and lasts exactly one cycle.
- The earliest next accepted `start` is the cycle after `done`.
- `busy` equals (state ∈ {SHIFT, GAP}) and is aligned with `dout_vld` at the frame edges.
- `frame_cnt` increments in the cycle after a frame's last bit.

## Test plan
- pat=8'b0000_1101, len=4, rep=0, gap=0, `start` at cycle 0 -> `dout`=1,1,0,1 with `dout_vld`=1 in cycles 1–4; `done`=1 in cycle 5 only; `busy` high in cycles 1–4. Feeding this stream into the sequence checker gives one detect.
- Same pattern with rep=2, gap=2 -> bits in cycles 1–4, 7–10 and 13–16; `dout_vld`=0 in cycles 5–6 and 11–12; `frame_cnt`=0/1/2 per frame; `done` in cycle 17.
- rep=1, gap=0, pat=8'hA5, len=0 -> 16 consecutive valid bits 1010_0101_1010_0101 in cycles 1–16; `done` in cycle 17.
- `start` pulsed again at cycle 3 of the first scenario with a different `pat` -> output is unchanged. `abort` at cycle 2 -> bits 1,1 are sent, `done` in cycle 3, IDLE in cycle 4.
- `rst` asserted asynchronously mid-cycle at cycle 6 of the second scenario -> all outputs are 0 before the next edge and `done` never pulses. After release, a new `start` is accepted normally.
- `start` and `abort` high together in IDLE -> no transfer, `busy` stays 0.
